fetch_controller: RTL and testbench

//  Sequences the instruction memory: owns the PC, drives word-aligned byte addresses to the

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_controller.sv | 125 ++++++++++++
 tb/tb_fetch_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // The all-zero word stops fetching.
  localparam logic [31:0] HALT_INSTR  = 32'h0;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries between the fetch stage and decode.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; flush beats push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty on power-of-2 depths.
  logic [PW:0]  wptr_q, wptr_d;
  logic [PW:0]  rptr_q, rptr_d;
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  // Head is forced to zero when empty so decode never sees stale data.
  assign head  = empty ? '0 : mem_q[rptr_q[PW-1:0]];

  // Next pointers and storage: flush resets the pointers, otherwise push/pop advance them.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    mem_d   = mem_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q[PW-1:0]] = push_entry;
        wptr_d = wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_d = rptr_q + 1'b1;
      end
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Owns the PC, reads the instruction memory and queues {pc, instr} entries for decode.
// Latency: start -> imem_addr=RESET_PC next cycle -> id_valid the cycle after; redirect likewise 2 cycles.
// Backpressure: id_ready low fills the buffer, then the PC holds until decode pops an entry.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          MEM_WORDS  = 1280,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_flush;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t fifo_head;
  fetch_entry_t fetch_entry;
  logic         pc_illegal;
  logic         room;

  assign fetch_entry = '{pc: pc_q, instr: imem_rdata};
  // Misaligned or beyond the memory; wrapped PCs also land here first.
  assign pc_illegal  = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= MEM_WORDS_L);
  // A redirect discards the head, so it is never counted as accepted.
  assign fifo_pop    = !fifo_empty && id_ready && !redirect_valid;
  // A full buffer still has room if decode drains the head this cycle.
  assign room        = !fifo_full || fifo_pop;

  // Next state, PC and fault flag; redirect outranks start and fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (redirect_valid) begin
      fifo_flush = 1'b1;
      pc_d       = redirect_pc;
      state_d    = RUN;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (start) begin
            fifo_flush = 1'b1;
            pc_d       = RESET_PC;
            fault_d    = 1'b0;
            state_d    = RUN;
          end
        end
        RUN: begin
          if (pc_illegal) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else if (room) begin
            if (imem_rdata == HALT_INSTR) begin
              state_d = HALT;
            end else begin
              fifo_push = 1'b1;
              pc_d      = pc_q + INSTR_BYTES;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, PC and sticky fault registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (fetch_entry),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign imem_addr = pc_q;
  assign id_valid  = !fifo_empty;
  assign id_instr  = fifo_head.instr;
  assign id_pc     = fifo_head.pc;
  assign busy      = (state_q == RUN);
  assign halted    = (state_q == HALT);
  assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a combinational-read memory model.
// Latency: n/a.
// Backpressure: id_ready driven directly by the directed steps.
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        halted;
  logic        fault;

  logic [31:0] mem [0:1279];
  int          tests;
  int          fails;

  fetch_controller #(
    .RESET_PC   (32'h0),
    .MEM_WORDS  (1280),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .halted         (halted),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read instruction memory; out-of-range reads return zero.
  always_comb begin
    imem_rdata = 32'h0;
    if (imem_addr[31:2] < 30'd1280) imem_rdata = mem[imem_addr[12:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_default();
    for (int i = 0; i < 1280; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h0000_2083;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".id_valid"}, {31'b0, id_valid}, 32'h0);
    check({tag, ".id_instr"}, id_instr, 32'h0);
    check({tag, ".id_pc"}, id_pc, 32'h0);
    check({tag, ".imem_addr"}, imem_addr, 32'h0);
    check({tag, ".busy"}, {31'b0, busy}, 32'h0);
    check({tag, ".halted"}, {31'b0, halted}, 32'h0);
    check({tag, ".fault"}, {31'b0, fault}, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    rst_n          = 1'b0;
    start          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    load_default();

    // 1: reset values, start latency, sequential stream
    tick();
    check_reset_outputs("t1_reset");
    rst_n = 1'b1;
    tick();
    check("t1_idle_busy", {31'b0, busy}, 32'h0);
    id_ready = 1'b1;
    pulse_start();
    check("t1_n1_busy", {31'b0, busy}, 32'h1);
    check("t1_n1_addr", imem_addr, 32'h0);
    check("t1_n1_valid", {31'b0, id_valid}, 32'h0);
    tick();
    check("t1_n2_valid", {31'b0, id_valid}, 32'h1);
    check("t1_n2_pc", id_pc, 32'h0);
    check("t1_n2_instr", id_instr, 32'h0000_2083);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("t1_stream_pc", id_pc, 32'(4 * i));
      check("t1_stream_instr", id_instr, 32'h1000_0000 | 32'(i));
    end

    // 2: decode stalled, buffer fills and PC holds
    do_reset();
    id_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    check("t2_hold_valid", {31'b0, id_valid}, 32'h1);
    check("t2_hold_pc", id_pc, 32'h0);
    check("t2_hold_addr", imem_addr, 32'h8);
    id_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("t2_drain_valid", {31'b0, id_valid}, 32'h1);
      check("t2_drain_pc", id_pc, 32'(4 * i));
    end

    // 3: zero word at word 12 halts after 0x2C
    mem[12] = 32'h0;
    do_reset();
    id_ready = 1'b1;
    pulse_start();
    tick();
    for (int i = 0; i < 12; i++) begin
      check("t3_seq_valid", {31'b0, id_valid}, 32'h1);
      check("t3_seq_pc", id_pc, 32'(4 * i));
      tick();
    end
    check("t3_halted", {31'b0, halted}, 32'h1);
    check("t3_empty", {31'b0, id_valid}, 32'h0);
    check("t3_addr", imem_addr, 32'h30);
    tick();
    check("t3_still_empty", {31'b0, id_valid}, 32'h0);
    check("t3_not_busy", {31'b0, busy}, 32'h0);
    load_default();

    // 4: redirect with a full buffer drops held entries
    do_reset();
    id_ready = 1'b0;
    pulse_start();
    tick();
    tick();
    check("t4_full_pc", id_pc, 32'h0);
    check("t4_full_addr", imem_addr, 32'h8);
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h18;
    tick();
    redirect_valid = 1'b0;
    check("t4_r1_valid", {31'b0, id_valid}, 32'h0);
    check("t4_r1_addr", imem_addr, 32'h18);
    tick();
    check("t4_r2_valid", {31'b0, id_valid}, 32'h1);
    check("t4_r2_pc", id_pc, 32'h18);
    tick();
    check("t4_r3_pc", id_pc, 32'h1C);

    // 5: illegal redirect targets fault, start clears
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1400;
    tick();
    redirect_valid = 1'b0;
    check("t5a_r1_valid", {31'b0, id_valid}, 32'h0);
    tick();
    check("t5a_fault", {31'b0, fault}, 32'h1);
    check("t5a_halted", {31'b0, halted}, 32'h1);
    check("t5a_valid", {31'b0, id_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1A;
    tick();
    redirect_valid = 1'b0;
    check("t5b_busy", {31'b0, busy}, 32'h1);
    check("t5b_addr", imem_addr, 32'h1A);
    tick();
    check("t5b_fault", {31'b0, fault}, 32'h1);
    check("t5b_halted", {31'b0, halted}, 32'h1);
    check("t5b_valid", {31'b0, id_valid}, 32'h0);
    pulse_start();
    check("t5c_fault", {31'b0, fault}, 32'h0);
    check("t5c_busy", {31'b0, busy}, 32'h1);
    check("t5c_addr", imem_addr, 32'h0);
    tick();
    check("t5c_valid", {31'b0, id_valid}, 32'h1);
    check("t5c_pc", id_pc, 32'h0);

    // 6: mid-run reset with buffered entries
    id_ready = 1'b0;
    tick();
    tick();
    check("t6_pre_valid", {31'b0, id_valid}, 32'h1);
    do_reset();
    check_reset_outputs("t6_reset");
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_idle_valid", {31'b0, id_valid}, 32'h0);
    end
    check("t6_idle_addr", imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
